// File: rtl/pulse_generator.sv
// pulse_generator
//   Programmable square-wave source. Drives FREQ_OUT low for a programmed
//   number of CLK cycles, then high for a programmed number of cycles, and
//   repeats. New lengths come in through a one-deep valid/ready slot and are
//   only applied at a period boundary (entry into the low phase), so a
//   running waveform never produces a glitched period.
//
// Ports
//   CLK          system clock, rising edge
//   RST_N        asynchronous reset, active HIGH (legacy name)
//   EN           run request; the current period always completes
//   CFG_VALID    HIGH_IN/LOW_IN hold a new setting
//   CFG_READY    pending slot empty (combinational)
//   HIGH_IN      requested high-phase length, 0 is treated as 1
//   LOW_IN       requested low-phase length, 0 is treated as 1
//   FREQ_OUT     generated waveform (registered)
//   PULSE        strobe on the first cycle of each high phase
//   PERIOD_DONE  strobe on the last cycle of each high phase
//   BUSY         generator is in the low or high phase
module pulse_generator #(
   parameter int COUNTER_BITS = 16
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic                    EN,
   input  logic                    CFG_VALID,
   output logic                    CFG_READY,
   input  logic [COUNTER_BITS-1:0] HIGH_IN,
   input  logic [COUNTER_BITS-1:0] LOW_IN,
   output logic                    FREQ_OUT,
   output logic                    PULSE,
   output logic                    PERIOD_DONE,
   output logic                    BUSY
);

   typedef logic [COUNTER_BITS-1:0] len_t;
   typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_t;

   localparam len_t ONE = len_t'(1);

   state_t state, state_nxt;
   len_t   cnt, cnt_nxt;
   len_t   active_high, active_low;
   len_t   pending_high, pending_low;
   logic   pending_valid;
   logic   boundary;
   logic   accept;
   logic   freq_q, pulse_q, done_q, busy_q;

   assign CFG_READY   = ~pending_valid;
   assign accept      = CFG_VALID & ~pending_valid;
   assign FREQ_OUT    = freq_q;
   assign PULSE       = pulse_q;
   assign PERIOD_DONE = done_q;
   assign BUSY        = busy_q;

   // Next-state / counter logic. A boundary (entry into LOW) reloads cnt from
   // whichever low length is in force after the pending slot is consumed.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      boundary  = 1'b0;
      case (state)
         S_IDLE: begin
            if (EN) boundary = 1'b1;
         end
         S_LOW: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - ONE;
            end else begin
               state_nxt = S_HIGH;
               cnt_nxt   = active_high - ONE;
            end
         end
         S_HIGH: begin
            if (cnt != '0)  cnt_nxt   = cnt - ONE;
            else if (EN)    boundary  = 1'b1;
            else            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (boundary) begin
         state_nxt = S_LOW;
         cnt_nxt   = (pending_valid ? pending_low : active_low) - ONE;
      end
   end

   always_ff @(posedge CLK or posedge RST_N) begin
      if (RST_N) begin
         state         <= S_IDLE;
         cnt           <= '0;
         active_high   <= ONE;
         active_low    <= ONE;
         pending_high  <= ONE;
         pending_low   <= ONE;
         pending_valid <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         // accept and consume are exclusive: a consume needs pending_valid=1,
         // which holds CFG_READY low.
         if (boundary && pending_valid) begin
            active_high   <= pending_high;
            active_low    <= pending_low;
            pending_valid <= 1'b0;
         end else if (accept) begin
            pending_high  <= (HIGH_IN == '0) ? ONE : HIGH_IN;
            pending_low   <= (LOW_IN  == '0) ? ONE : LOW_IN;
            pending_valid <= 1'b1;
         end
      end
   end

   // Outputs are flopped from the next state so they line up with the phase
   // the state register enters on the same edge.
   always_ff @(posedge CLK or posedge RST_N) begin
      if (RST_N) begin
         freq_q  <= 1'b0;
         pulse_q <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         freq_q  <= (state_nxt == S_HIGH);
         pulse_q <= (state_nxt == S_HIGH) && (state == S_LOW);
         done_q  <= (state_nxt == S_HIGH) && (cnt_nxt == '0);
         busy_q  <= (state_nxt != S_IDLE);
      end
   end

endmodule

// File: tb/tb_pulse_generator.sv
module tb_pulse_generator;
   localparam int W = 16;

   logic         CLK = 1'b0;
   logic         RST_N = 1'b1;
   logic         EN = 1'b0;
   logic         CFG_VALID = 1'b0;
   logic [W-1:0] HIGH_IN = '0;
   logic [W-1:0] LOW_IN = '0;
   logic         CFG_READY, FREQ_OUT, PULSE, PERIOD_DONE, BUSY;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   pulse_generator #(.COUNTER_BITS(W)) dut (
      .CLK(CLK), .RST_N(RST_N), .EN(EN), .CFG_VALID(CFG_VALID),
      .CFG_READY(CFG_READY), .HIGH_IN(HIGH_IN), .LOW_IN(LOW_IN),
      .FREQ_OUT(FREQ_OUT), .PULSE(PULSE), .PERIOD_DONE(PERIOD_DONE), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: position within the current period decides every
   // output; the period is L low cycles followed by H high cycles.
   bit m_run;
   int m_pos, m_L, m_H;
   bit p_valid;
   int p_L, p_H;

   function automatic int clamp(input logic [W-1:0] v);
      return (v == 0) ? 1 : int'(v);
   endfunction

   always @(posedge CLK or posedge RST_N) begin
      if (RST_N) begin
         m_run = 0; m_pos = 0; m_L = 1; m_H = 1; p_valid = 0; p_L = 1; p_H = 1;
      end else begin
         bit acc, start;
         acc   = CFG_VALID && !p_valid;
         start = 0;
         if (!m_run) start = EN;
         else if (m_pos == m_L + m_H - 1) begin
            if (EN) start = 1; else m_run = 0;
         end else m_pos++;
         if (start) begin
            if (p_valid) begin m_L = p_L; m_H = p_H; p_valid = 0; end
            m_pos = 0; m_run = 1;
         end
         if (acc) begin p_valid = 1; p_L = clamp(LOW_IN); p_H = clamp(HIGH_IN); end
      end
   end

   // Single compare process, every cycle outside reset.
   always @(negedge CLK) begin
      if (chk_en && !RST_N) begin
         check("busy",  BUSY,        m_run);
         check("freq",  FREQ_OUT,    m_run && m_pos >= m_L);
         check("pulse", PULSE,       m_run && m_pos == m_L);
         check("done",  PERIOD_DONE, m_run && m_pos == m_L + m_H - 1);
         check("ready", CFG_READY,   !p_valid);
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) @(negedge CLK);
   endtask

   task automatic cfg(input int h, input int l);
      HIGH_IN = W'(h); LOW_IN = W'(l); CFG_VALID = 1'b1;
      cyc();
      CFG_VALID = 1'b0;
   endtask

   task automatic capture(input int n, output logic [15:0] f, output logic [15:0] p,
                          output logic [15:0] d);
      f = '0; p = '0; d = '0;
      for (int i = 0; i < n; i++) begin
         f[i] = FREQ_OUT; p[i] = PULSE; d[i] = PERIOD_DONE;
         cyc();
      end
   endtask

   task automatic do_reset();
      #2 RST_N = 1'b1;
      #1;
      check("rst_freq",  FREQ_OUT, 0);
      check("rst_busy",  BUSY, 0);
      check("rst_pulse", PULSE, 0);
      check("rst_done",  PERIOD_DONE, 0);
      check("rst_ready", CFG_READY, 1);
      cyc(2);
      RST_N = 1'b0;
   endtask

   initial begin
      logic [15:0] f, p, d;
      int budget;
      cyc(2);
      do_reset();
      chk_en = 1'b1;
      cyc();

      // 3 high / 5 low configured while idle, then run
      cfg(3, 5);
      EN = 1'b1;
      cyc();
      capture(16, f, p, d);
      check("lit35_freq",  f, 16'hE0E0);
      check("lit35_pulse", p, 16'h2020);
      check("lit35_done",  d, 16'h8080);
      check("lit35_busy",  BUSY, 1);

      // minimum period: zeros clamp to 1/1 from the next boundary
      cfg(0, 0);
      budget = 0;
      while (!(PERIOD_DONE && FREQ_OUT) && budget < 50) begin cyc(); budget++; end
      check("wait_done", budget < 50, 1);
      cyc();                      // first 3/5 boundary after cfg -> 1/1 period begins
      capture(16, f, p, d);
      check("min_freq",  f, 16'hAAAA);
      check("min_pulse", p, 16'hAAAA);
      check("min_done",  d, 16'hAAAA);

      // graceful stop in a 6-cycle high phase
      cfg(6, 2);
      budget = 0;
      while (!PULSE && budget < 50) begin cyc(); budget++; end
      while (!(PULSE && !PERIOD_DONE) && budget < 50) begin cyc(); budget++; end
      check("wait_pulse6", budget < 50, 1);
      cyc(2);
      EN = 1'b0;
      cyc(4);                     // remaining high cycles + first idle cycle
      check("stop_busy", BUSY, 0);
      check("stop_freq", FREQ_OUT, 0);
      EN = 1'b1;
      cyc();
      check("restart_busy", BUSY, 1);

      // async reset during a high phase
      budget = 0;
      while (!FREQ_OUT && budget < 50) begin cyc(); budget++; end
      check("wait_high", budget < 50, 1);
      cyc();
      do_reset();

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         EN        = ($urandom_range(0, 15) != 0);
         CFG_VALID = ($urandom_range(0, 3) == 0);
         HIGH_IN   = W'($urandom_range(0, 12));
         LOW_IN    = W'($urandom_range(0, 12));
         if (i % 1000 == 999) do_reset();
         else cyc();
      end
      CFG_VALID = 1'b0;
      EN = 1'b0;
      cyc(40);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, expected finish");
      $fatal(1);
   end
endmodule
